// File: rtl/core_pipe_pkg.sv
// Shared pipeline types for the core: default widths, WB payload layout and skid-buffer states.
package core_pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned RD_W_DEF   = 5;
  localparam int unsigned ZERO_REG   = 0;

  typedef struct packed {
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [DATA_W_DEF-1:0] read_data;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [RD_W_DEF-1:0]   rd;
  } wb_payload_t;

  // Encoded as {main_valid, skid_valid}; 2'b01 cannot occur.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main entry drives the output, skid entry absorbs one beat so
// in_ready comes straight from a flop and never depends on out_ready.
module pipe_skid_buf
  import core_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept, drain;
  skid_state_e      state;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

  assign accept = in_valid & in_ready;
  assign drain  = main_valid_q & out_ready;
  assign state  = skid_state_e'({main_valid_q, skid_valid_q});

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    // Flush drops valids only; payload stays put and a simultaneous accept is discarded.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case (state)
        StEmpty: begin
          if (accept) begin
            main_d       = in_data;
            main_valid_d = 1'b1;
          end
        end
        StOne: begin
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
          end else if (drain) begin
            main_valid_d = 1'b0;
          end
        end
        StFull: begin
          if (drain) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline stage with valid/ready handshake, skid buffering, flush and x0 write guard.
// Optional stall_cycles counter enabled by defining MEM_WB_STALL_CNT_EN.
module mem_wb_skid_stage
  import core_pipe_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned RD_W           = RD_W_DEF,
  parameter int unsigned ZERO_REG_GUARD = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [RD_W-1:0]   reg_rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_to_reg_out,
  output logic              reg_write_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [RD_W-1:0]   reg_rd_out
`ifdef MEM_WB_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  // Same field order as wb_payload_t, resized to this instance's widths.
  typedef struct packed {
    logic              mem_to_reg;
    logic              reg_write;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [RD_W-1:0]   rd;
  } payload_t;

  localparam int unsigned PayloadW = $bits(payload_t);

  payload_t in_pay, out_pay;
  logic     rd_is_zero;
  logic     guard_hit;

  assign in_pay.mem_to_reg = mem_to_reg_in;
  assign in_pay.reg_write  = reg_write_in;
  assign in_pay.read_data  = read_data_in;
  assign in_pay.alu_result = alu_result_in;
  assign in_pay.rd         = reg_rd_in;

  pipe_skid_buf #(
    .WIDTH (PayloadW)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay)
  );

  assign rd_is_zero = (out_pay.rd == RD_W'(ZERO_REG));
  assign guard_hit  = (ZERO_REG_GUARD != 0) && rd_is_zero;

  assign mem_to_reg_out = out_pay.mem_to_reg & out_valid;
  assign reg_write_out  = out_pay.reg_write & out_valid & ~guard_hit;
  assign read_data_out  = out_pay.read_data;
  assign alu_result_out = out_pay.alu_result;
  assign reg_rd_out     = out_pay.rd;

`ifdef MEM_WB_STALL_CNT_EN
  logic [31:0] stall_q;

  // Wraps naturally at 2^32-1; flush does not clear it.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed self-checking bench for mem_wb_skid_stage (guarded and unguarded x0 instances).
module tb_mem_wb_skid_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic          clock = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          mem_to_reg_in, reg_write_in;
  logic [DW-1:0] read_data_in, alu_result_in;
  logic [RW-1:0] reg_rd_in;

  logic          in_ready, out_valid, mem_to_reg_out, reg_write_out;
  logic [DW-1:0] read_data_out, alu_result_out;
  logic [RW-1:0] reg_rd_out;

  logic          ng_in_ready, ng_out_valid, ng_mem_to_reg_out, ng_reg_write_out;
  logic [DW-1:0] ng_read_data_out, ng_alu_result_out;
  logic [RW-1:0] ng_reg_rd_out;

`ifdef MEM_WB_STALL_CNT_EN
  logic [31:0]   stall_cycles, ng_stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_wb_skid_stage #(
    .DATA_W         (DW),
    .RD_W           (RW),
    .ZERO_REG_GUARD (1)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_to_reg_in  (mem_to_reg_in),
    .reg_write_in   (reg_write_in),
    .read_data_in   (read_data_in),
    .alu_result_in  (alu_result_in),
    .reg_rd_in      (reg_rd_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .mem_to_reg_out (mem_to_reg_out),
    .reg_write_out  (reg_write_out),
    .read_data_out  (read_data_out),
    .alu_result_out (alu_result_out),
    .reg_rd_out     (reg_rd_out)
`ifdef MEM_WB_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  mem_wb_skid_stage #(
    .DATA_W         (DW),
    .RD_W           (RW),
    .ZERO_REG_GUARD (0)
  ) dut_ng (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (ng_in_ready),
    .mem_to_reg_in  (mem_to_reg_in),
    .reg_write_in   (reg_write_in),
    .read_data_in   (read_data_in),
    .alu_result_in  (alu_result_in),
    .reg_rd_in      (reg_rd_in),
    .out_valid      (ng_out_valid),
    .out_ready      (out_ready),
    .mem_to_reg_out (ng_mem_to_reg_out),
    .reg_write_out  (ng_reg_write_out),
    .read_data_out  (ng_read_data_out),
    .alu_result_out (ng_alu_result_out),
    .reg_rd_out     (ng_reg_rd_out)
`ifdef MEM_WB_STALL_CNT_EN
    ,
    .stall_cycles   (ng_stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic m2r, input logic rw, input logic [RW-1:0] rd,
                       input logic [DW-1:0] alu, input logic [DW-1:0] rdata);
    in_valid      = v;
    mem_to_reg_in = m2r;
    reg_write_in  = rw;
    reg_rd_in     = rd;
    alu_result_in = alu;
    read_data_in  = rdata;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_m2r"}, {31'd0, mem_to_reg_out}, 32'd0);
    check({tag, "_rw"}, {31'd0, reg_write_out}, 32'd0);
    check({tag, "_rdata"}, read_data_out, 32'd0);
    check({tag, "_alu"}, alu_result_out, 32'd0);
    check({tag, "_rd"}, {27'd0, reg_rd_out}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_idle("rst");

    // Back-to-back stream: each entry visible right after its accept edge.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i[0], 1'b1, RW'(i), 32'h10 + 32'(i - 1), 32'h100 + 32'(i));
      tick();
      check($sformatf("strm%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("strm%0d_alu", i), alu_result_out, 32'h10 + 32'(i - 1));
      check($sformatf("strm%0d_rd", i), {27'd0, reg_rd_out}, 32'(i));
      check($sformatf("strm%0d_rdata", i), read_data_out, 32'h100 + 32'(i));
      check($sformatf("strm%0d_m2r", i), {31'd0, mem_to_reg_out}, 32'(i % 2));
      check($sformatf("strm%0d_rw", i), {31'd0, reg_write_out}, 32'd1);
      check($sformatf("strm%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    check("strm_end_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure fills both entries, then drains in order.
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'hAAAA, 32'h0);
    tick();
    check("bp_a_valid", {31'd0, out_valid}, 32'd1);
    check("bp_a_alu", alu_result_out, 32'hAAAA);
    check("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 5'd4, 32'hBBBB, 32'h0);
    tick();
    check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_full_alu", alu_result_out, 32'hAAAA);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_alu", alu_result_out, 32'hAAAA);
    check("bp_hold_rd", {27'd0, reg_rd_out}, 32'd3);
    out_ready = 1'b1;
    tick();
    check("bp_b_valid", {31'd0, out_valid}, 32'd1);
    check("bp_b_alu", alu_result_out, 32'hBBBB);
    check("bp_b_rd", {27'd0, reg_rd_out}, 32'd4);
    check("bp_b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_done_valid", {31'd0, out_valid}, 32'd0);

    // Flush in FULL together with a new entry C.
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'hAAAA, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 5'd6, 32'hBBBB, 32'h0);
    tick();
    check("fl_pre_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 5'd7, 32'hCCCC, 32'h0);
    tick();
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    check("fl_rw", {31'd0, reg_write_out}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl_post%0d_valid", i), {31'd0, out_valid}, 32'd0);
    end

    // Reset while FULL.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h1234, 32'h5678);
    tick();
    drive(1'b1, 1'b1, 1'b1, 5'd10, 32'h4321, 32'h8765);
    tick();
    check("rf_pre_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("rst_full");
`ifdef MEM_WB_STALL_CNT_EN
    check("rst_full_stall", stall_cycles, 32'd0);
`endif

    // x0 guard and mem_to_reg gating.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 5'd0, 32'h77, 32'h88);
    tick();
    drive(1'b0, 1'b1, 1'b1, 5'd0, 32'h0, 32'h0);
    check("x0_guard_rw", {31'd0, reg_write_out}, 32'd0);
    check("x0_noguard_rw", {31'd0, ng_reg_write_out}, 32'd1);
    check("x0_m2r", {31'd0, mem_to_reg_out}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("x0_drained_valid", {31'd0, out_valid}, 32'd0);
    check("m2r_gated", {31'd0, mem_to_reg_out}, 32'd0);
    check("rw_gated_ng", {31'd0, ng_reg_write_out}, 32'd0);
    check("rdata_held", read_data_out, 32'h88);

`ifdef MEM_WB_STALL_CNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd2, 32'h5, 32'h6);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("stall_start", stall_cycles, 32'd0);
    repeat (5) tick();
    check("stall_five", stall_cycles, 32'd5);
    // out_ready high on the flush edge so that edge is not a stall cycle.
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("stall_after_flush", stall_cycles, 32'd5);
    tick();
    check("stall_kept", stall_cycles, 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("stall_reset", stall_cycles, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised MEM/WB pipeline stage for the RISC-V core, the successor to the plain MEM/WB register.
- Carries WB control, load data, ALU result and rd address from the MEM stage to the WB stage.
- Adds a valid/ready handshake, a 2-entry skid buffer so the upstream ready path is fully registered, a synchronous flush, and x0 write suppression.
- Sits between the data-memory read path and the register-file write port.

Parameters:
- DATA_W, 32, width of read_data and alu_result.
- RD_W, 5, width of the destination register address.
- ZERO_REG_GUARD, 1, when 1 a write to rd==0 never asserts reg_write_out.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry; registered
- mem_to_reg_in  in  1  WB mux select (1 = memory data)
- reg_write_in  in  1  register-file write enable
- read_data_in  in  DATA_W  data read from memory
- alu_result_in  in  DATA_W  ALU result
- reg_rd_in  in  RD_W  destination register
- out_valid  out  1  output entry valid
- out_ready  in  1  WB side accepts the output entry
- mem_to_reg_out  out  1  gated by out_valid
- reg_write_out  out  1  gated by out_valid and the x0 guard
- read_data_out  out  DATA_W  held data
- alu_result_out  out  DATA_W  held data
- reg_rd_out  out  RD_W  held rd
- stall_cycles  out  32  present only with MEM_WB_STALL_CNT_EN

Behaviour:
- Reset (synchronous, active-high), next edge: main_valid=0, skid_valid=0, all payload registers=0, in_ready=1, out_valid=0, every output=0.
- Storage: main entry M (drives the outputs) and skid entry S. Each entry holds payload plus a valid bit.
- Handshakes: accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = !S.valid, registered; it is never combinationally dependent on out_ready.
- out_valid = M.valid.
- Latency: an entry accepted at edge N appears on the outputs after edge N when M is empty or draining.
- Throughput: 1 entry/cycle while out_ready=1.
- State transitions per edge, using (M.valid, S.valid) as EMPTY(0,0), ONE(1,0), FULL(1,1):
  - EMPTY: accept -> load M -> ONE.
  - ONE: accept & drain -> load M -> ONE. Accept & !drain -> load S -> FULL. Drain & !accept -> EMPTY.
  - FULL: drain -> M<=S, S.valid<=0 -> ONE. No accept is possible because in_ready=0.
- State (0,1) is illegal and unreachable.
- Output gating:
  - mem_to_reg_out = M.mem_to_reg & M.valid.
  - reg_write_out = M.reg_write & M.valid & !(ZERO_REG_GUARD & (M.rd==0)).
  - Data and rd outputs show M payload regardless of valid.
- Payload order is strictly FIFO; no entry is reordered, duplicated or dropped except by flush.
- Flush: at the edge it is sampled, M.valid=0 and S.valid=0; in_ready=1 on the following cycle.
- Flush has priority over a simultaneous accept: that entry is discarded.
- Payload registers are not cleared on flush.
- Reset mid-operation: identical to reset from idle; any in-flight entries are lost.

Optional Feature:
- Macro: MEM_WB_STALL_CNT_EN.
- Defined: port stall_cycles exists. It is a 32-bit counter incremented each cycle with out_valid & !out_ready, wrapping at 2^32-1 to 0. Cleared by reset; not cleared by flush.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package core_pipe_pkg holds:
  - DATA_W and RD_W defaults.
  - A wb_payload_t struct {mem_to_reg, reg_write, read_data, alu_result, rd}.
  - ZERO_REG localparam = 0.
- One sub-module, pipe_skid_buf, is natural: a generic 2-entry skid buffer over a width-parametrised payload vector.
- mem_wb_skid_stage instantiates pipe_skid_buf and adds output gating, the x0 guard and the optional counter.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, all outputs 0. Assert reset with FULL state -> next cycle EMPTY, outputs 0.
- Stream of 8 entries, rd=1..8, alu_result=0x10..0x17, out_ready=1 -> each appears 1 cycle after accept, in order, no bubbles, in_ready stays 1.
- out_ready=0, push A(alu=0xAAAA) then B(alu=0xBBBB) -> FULL, in_ready=0 next cycle. Raise out_ready -> A drains, then B, in_ready=1 after the first drain.
- In FULL, flush=1 together with in_valid=1 (C) -> next cycle out_valid=0, in_ready=1, C never appears.
- reg_write_in=1, rd=0, ZERO_REG_GUARD=1 -> reg_write_out=0. Same stimulus with ZERO_REG_GUARD=0 -> reg_write_out=1. mem_to_reg_in=1 with out_valid=0 -> mem_to_reg_out=0.
- With MEM_WB_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cycles=5. Flush -> stall_cycles stays 5. Reset -> 0.
